// File: rtl/etx_pkg.sv
// Shared eMesh packet field layout: where the destination address lives and
// which address bits carry the chip ID.
package etx_pkg;

  localparam int DST_OFS = 8;
  localparam int DST_W   = 32;
  localparam int ID_LSB  = 20;
  localparam int ID_W    = 12;

  function automatic int pkt_width(input int aw);
    return 2 * aw + 40;
  endfunction

  // A packet addressed to our own chip ID goes to the configuration block.
  function automatic logic cfg_hit(input logic [DST_W-1:0] dst,
                                   input logic [ID_W-1:0]  id);
    return dst[ID_LSB +: ID_W] == id;
  endfunction

endpackage

// File: rtl/oh_rrarbiter.sv
// One-hot round-robin picker: the search starts just after ptr and wraps.
// Passing ptr = N-1 gives plain lowest-index-first priority.
module oh_rrarbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     requests,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grants
);

  logic [PTR_W-1:0] w_start;
  logic [N-1:0]     w_rot;
  logic [N-1:0]     w_rot_gnt;

  assign w_start = (ptr == PTR_W'(N - 1)) ? '0 : ptr + PTR_W'(1);

  // Rotate so the start channel sits at bit 0, isolate the lowest set bit,
  // then rotate the single grant back to its channel position.
  assign w_rot     = N'({requests, requests} >> w_start);
  assign w_rot_gnt = w_rot & (~w_rot + N'(1));
  assign grants    = N'({w_rot_gnt, w_rot_gnt} >> (N - int'(w_start)));

endmodule

// File: rtl/etx_rr_arbiter.sv
// N-channel eMesh transmit arbiter: one grant per cycle, routed by destination
// chip ID to either the elink IO register or the local config register.
module etx_rr_arbiter
  import etx_pkg::*;
#(
  parameter int            AW = 32,
  parameter int            PW = pkt_width(AW),
  parameter int            N  = 4,
  parameter logic [ID_W-1:0] ID = 12'h000,
  parameter bit            RR = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    in_access,
  input  logic [N*PW-1:0] in_packet,
  output logic [N-1:0]    in_wait,
  output logic            etx_access,
  output logic [PW-1:0]   etx_packet,
  input  logic            etx_wait,
  output logic            cfg_access,
  output logic [PW-1:0]   cfg_packet,
  input  logic            cfg_wait
);

  localparam int               PTR_W   = (N > 1) ? $clog2(N) : 1;
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(N - 1);

  logic [N-1:0]     w_cfg_match;
  logic [N-1:0]     w_elig;
  logic [N-1:0]     w_grant;
  logic             w_etx_rdy;
  logic             w_cfg_rdy;
  logic [PTR_W-1:0] w_arb_ptr;
  logic [PW-1:0]    w_gnt_pkt;
  logic             w_gnt_cfg;
  logic             w_any;

  logic [PTR_W-1:0] r_ptr;
  logic             r_etx_vld_p1;
  logic             r_cfg_vld_p1;
  logic [PW-1:0]    r_etx_pkt_p1;
  logic [PW-1:0]    r_cfg_pkt_p1;

  function automatic logic [PTR_W-1:0] onehot_idx(input logic [N-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = idx | PTR_W'(i);
    end
    return idx;
  endfunction

  for (genvar i = 0; i < N; i++) begin : g_dec
    assign w_cfg_match[i] = cfg_hit(in_packet[i*PW + DST_OFS +: DST_W], ID);
  end

  // A request only competes if the output it targets can take a packet.
  assign w_etx_rdy = ~r_etx_vld_p1 | ~etx_wait;
  assign w_cfg_rdy = ~r_cfg_vld_p1 | ~cfg_wait;
  assign w_elig    = in_access & ((w_cfg_match & {N{w_cfg_rdy}}) |
                                  (~w_cfg_match & {N{w_etx_rdy}}));
  assign w_arb_ptr = RR ? r_ptr : PTR_RST;

  oh_rrarbiter #(.N(N), .PTR_W(PTR_W)) u_arb (
    .requests (w_elig),
    .ptr      (w_arb_ptr),
    .grants   (w_grant)
  );

  assign in_wait = in_access & ~w_grant;
  assign w_any   = |w_grant;

  always_comb begin
    w_gnt_pkt = '0;
    w_gnt_cfg = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_gnt_pkt = w_gnt_pkt | in_packet[i*PW +: PW];
        w_gnt_cfg = w_gnt_cfg | w_cfg_match[i];
      end
    end
  end

  // ---- stage p1: output registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_etx_vld_p1 <= 1'b0;
      r_cfg_vld_p1 <= 1'b0;
      r_etx_pkt_p1 <= '0;
      r_cfg_pkt_p1 <= '0;
      r_ptr        <= PTR_RST;
    end else begin
      if (w_any && !w_gnt_cfg) begin
        r_etx_vld_p1 <= 1'b1;
        r_etx_pkt_p1 <= w_gnt_pkt;
      end else if (!etx_wait) begin
        r_etx_vld_p1 <= 1'b0;
      end
      if (w_any && w_gnt_cfg) begin
        r_cfg_vld_p1 <= 1'b1;
        r_cfg_pkt_p1 <= w_gnt_pkt;
      end else if (!cfg_wait) begin
        r_cfg_vld_p1 <= 1'b0;
      end
      if (RR && w_any) r_ptr <= onehot_idx(w_grant);
    end
  end

  assign etx_access = r_etx_vld_p1;
  assign etx_packet = r_etx_pkt_p1;
  assign cfg_access = r_cfg_vld_p1;
  assign cfg_packet = r_cfg_pkt_p1;

endmodule

// File: tb/tb_etx_rr_arbiter.sv
// Bench for etx_rr_arbiter: a round-robin and a fixed-priority instance share
// one stimulus stream and are both compared against a cycle model each cycle.
module tb_etx_rr_arbiter;

  localparam int AW = 32;
  localparam int PW = 2 * AW + 40;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_access;
  logic [N*PW-1:0] in_packet;
  logic            etx_wait;
  logic            cfg_wait;

  logic [N-1:0]  in_wait0, in_wait1;
  logic          etx_access0, etx_access1, cfg_access0, cfg_access1;
  logic [PW-1:0] etx_packet0, etx_packet1, cfg_packet0, cfg_packet1;

  always #5 clk = ~clk;

  etx_rr_arbiter #(.AW(AW), .PW(PW), .N(N), .ID(12'h000), .RR(1'b1)) u_rr (
    .clk(clk), .reset(reset), .in_access(in_access), .in_packet(in_packet),
    .in_wait(in_wait0), .etx_access(etx_access0), .etx_packet(etx_packet0),
    .etx_wait(etx_wait), .cfg_access(cfg_access0), .cfg_packet(cfg_packet0),
    .cfg_wait(cfg_wait)
  );

  etx_rr_arbiter #(.AW(AW), .PW(PW), .N(N), .ID(12'h000), .RR(1'b0)) u_fp (
    .clk(clk), .reset(reset), .in_access(in_access), .in_packet(in_packet),
    .in_wait(in_wait1), .etx_access(etx_access1), .etx_packet(etx_packet1),
    .etx_wait(etx_wait), .cfg_access(cfg_access1), .cfg_packet(cfg_packet1),
    .cfg_wait(cfg_wait)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit            m_ev[2];
  bit            m_cv[2];
  logic [PW-1:0] m_ep[2];
  logic [PW-1:0] m_cp[2];
  int            m_last = N - 1;
  bit            chk_en = 1'b0;

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_ev[m] = 0; m_cv[m] = 0; m_ep[m] = '0; m_cp[m] = '0;
    end
  end

  function automatic bit is_cfg(input int i);
    logic [31:0] d;
    d = in_packet[i*PW + 8 +: 32];
    return d[31:20] == 12'h000;
  endfunction

  // Index of the channel that must be granted this cycle, or -1.
  function automatic int pick(input int m);
    bit er, cr;
    bit el[N];
    int c;
    er = !m_ev[m] || !etx_wait;
    cr = !m_cv[m] || !cfg_wait;
    for (int i = 0; i < N; i++) el[i] = in_access[i] && (is_cfg(i) ? cr : er);
    if (m == 0) begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (el[c]) return c;
      end
    end else begin
      for (int i = 0; i < N; i++) if (el[i]) return i;
    end
    return -1;
  endfunction

  task automatic check_inst(input int m, input int g, input logic [N-1:0] w,
                            input logic ea, input logic [PW-1:0] ep,
                            input logic ca, input logic [PW-1:0] cp);
    logic [N-1:0] ew;
    string pfx;
    pfx = (m == 0) ? "rr" : "fp";
    for (int i = 0; i < N; i++) ew[i] = in_access[i] && (i != g);
    chk({pfx, "_in_wait"}, w, ew);
    chk({pfx, "_etx_access"}, ea, m_ev[m]);
    chk({pfx, "_etx_packet"}, ep, m_ep[m]);
    chk({pfx, "_cfg_access"}, ca, m_cv[m]);
    chk({pfx, "_cfg_packet"}, cp, m_cp[m]);
  endtask

  always @(negedge clk) begin
    int g[2];
    for (int m = 0; m < 2; m++) g[m] = pick(m);
    if (chk_en) begin
      check_inst(0, g[0], in_wait0, etx_access0, etx_packet0, cfg_access0, cfg_packet0);
      check_inst(1, g[1], in_wait1, etx_access1, etx_packet1, cfg_access1, cfg_packet1);
    end
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        m_ev[m] = 0; m_cv[m] = 0; m_ep[m] = '0; m_cp[m] = '0;
        if (m == 0) m_last = N - 1;
      end else begin
        if (m_ev[m] && !etx_wait) m_ev[m] = 0;
        if (m_cv[m] && !cfg_wait) m_cv[m] = 0;
        if (g[m] >= 0) begin
          if (is_cfg(g[m])) begin
            m_cv[m] = 1; m_cp[m] = in_packet[g[m]*PW +: PW];
          end else begin
            m_ev[m] = 1; m_ep[m] = in_packet[g[m]*PW +: PW];
          end
          if (m == 0) m_last = g[m];
        end
      end
    end
  end

  // ---------------- upstream source ----------------
  int          seq[N];
  logic [31:0] ch_dst[N];
  bit          rand_mode = 1'b0;

  task automatic build(input int i);
    in_packet[i*PW +: PW] = {32'(seq[i]), 32'($urandom), ch_dst[i], 8'(i)};
  endtask

  function automatic logic [31:0] rnd_dst();
    if ($urandom_range(0, 1) == 0) return {12'h000, 20'($urandom)};
    return {12'($urandom_range(1, 4095)), 20'($urandom)};
  endfunction

  // One clock; a channel whose request was taken presents its next packet.
  task automatic step();
    logic [N-1:0] xfer;
    @(negedge clk);
    xfer = in_access & ~in_wait0;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (xfer[i]) begin
        seq[i]++;
        if (rand_mode) begin
          ch_dst[i]    = rnd_dst();
          in_access[i] = ($urandom_range(0, 3) != 0);
        end
        build(i);
      end else if (rand_mode && !in_access[i]) begin
        in_access[i] = ($urandom_range(0, 1) == 1);
        ch_dst[i]    = rnd_dst();
        build(i);
      end
    end
    if (rand_mode) begin
      etx_wait = ($urandom_range(0, 2) == 0);
      cfg_wait = ($urandom_range(0, 2) == 0);
      reset    = ($urandom_range(0, 99) == 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  logic [PW-1:0] hold, exp_p;

  initial begin
    reset = 1'b1; etx_wait = 1'b0; cfg_wait = 1'b0; in_access = '1;
    for (int i = 0; i < N; i++) begin
      seq[i] = 0; ch_dst[i] = 32'h8080_0000; build(i);
    end

    // reset held 3 cycles with every channel requesting
    for (int k = 0; k < 3; k++) begin
      step();
      chk_en = 1'b1;
      chk("reset_etx_access", etx_access0, 0);
      chk("reset_cfg_access", cfg_access0, 0);
      chk("reset_etx_packet", etx_packet0, 0);
    end

    // round-robin order 0,1,2,3,... with no gaps; fixed priority sticks at 0
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_order", etx_packet0[7:0], k % 4);
      chk("rr_valid", etx_access0, 1);
      chk("fp_order", etx_packet1[7:0], 0);
    end

    // fixed priority with channels 1 and 3
    in_access = 4'b1010;
    #1;
    chk("fp_wait", in_wait1, 4'b1000);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("fp_grant", etx_packet1[7:0], 1);
      chk("fp_wait", in_wait1, 4'b1000);
    end

    // split backpressure: ch0 to cfg stalls, ch1 streams to IO
    reset = 1'b1;
    step();
    reset = 1'b0;
    ch_dst[0] = 32'h0000_0F00; ch_dst[1] = 32'h8080_0000;
    build(0); build(1);
    in_access = 4'b0011;
    hold = in_packet[0 +: PW];
    step();
    cfg_wait = 1'b1;
    chk("split_cfg_access", cfg_access0, 1);
    chk("split_cfg_packet", cfg_packet0, hold);
    for (int k = 0; k < 5; k++) begin
      exp_p = in_packet[PW +: PW];
      step();
      chk("split_etx_packet", etx_packet0, exp_p);
      chk("split_etx_access", etx_access0, 1);
      chk("split_cfg_hold", cfg_packet0, hold);
      chk("split_ch0_wait", in_wait0[0], 1);
    end
    cfg_wait = 1'b0;
    exp_p = in_packet[0 +: PW];
    #1;
    chk("split_release_wait", in_wait0[0], 0);
    step();
    chk("split_release_cfg", cfg_packet0, exp_p);
    chk("split_release_access", cfg_access0, 1);

    // IO output held under etx_wait, then drain and reload on the same edge
    reset = 1'b1;
    step();
    reset = 1'b0;
    ch_dst[0] = 32'h8080_0000; build(0);
    in_access = 4'b0001;
    hold = in_packet[0 +: PW];
    step();
    etx_wait = 1'b1;
    in_access = 4'b0011;
    chk("hold_load", etx_packet0, hold);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold_packet", etx_packet0, hold);
      chk("hold_access", etx_access0, 1);
      chk("hold_wait", in_wait0, 4'b0011);
    end
    exp_p = in_packet[PW +: PW];
    etx_wait = 1'b0;
    step();
    chk("drain_access", etx_access0, 1);
    chk("drain_reload", etx_packet0, exp_p);

    // reset in the middle of a stall; the waiting packet is sent afterwards
    in_access = 4'b0100;
    step();
    etx_wait = 1'b1;
    hold = in_packet[2*PW +: PW];
    step();
    chk("stall_wait", in_wait0, 4'b0100);
    chk("stall_access", etx_access0, 1);
    reset = 1'b1;
    step();
    chk("midrst_access", etx_access0, 0);
    chk("midrst_packet", etx_packet0, 0);
    reset = 1'b0;
    step();
    chk("resend_access", etx_access0, 1);
    chk("resend_packet", etx_packet0, hold);
    etx_wait = 1'b0;

    // randomized traffic, backpressure and occasional reset
    rand_mode = 1'b1;
    repeat (1500) step();
    rand_mode = 1'b0;
    reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
